fwvip_wb_target_mem: RTL and testbench
======================================

Name: fwvip_wb_target_mem

Overview:
Synthesizable Wishbone target (responder) backed by a word-addressed memory. It is the bus-side end that answers fwvip_wb_initiator_core transactions directly, replacing the RV-side memory responder model in back-to-back benches. It supports programmable wait states, byte-lane writes and error response for out-of-window or misaligned addresses.

Parameters:
ADDR_WIDTH, 32, Wishbone address width in bits
DATA_WIDTH, 32, data width in bits; multiple of 8
DEPTH, 256, memory depth in DATA_WIDTH words; power of two
BASE_ADDR, 0, byte address of word 0
WAIT_STATES, 0, extra cycles inserted before ack/err (0..15)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
t_adr  in  ADDR_WIDTH  byte address
t_dat_w  in  DATA_WIDTH  write data
t_dat_r  out  DATA_WIDTH  read data
t_cyc  in  1  bus cycle active
t_stb  in  1  strobe
t_we  in  1  1 = write
t_sel  in  DATA_WIDTH/8  byte-lane selects
t_ack  out  1  normal termination
t_err  out  1  error termination
busy  out  1  high while a transfer is held (WAIT or RESP state)

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; t_ack=0, t_err=0, t_dat_r=0, busy=0, wait counter=0. Memory contents are not reset.
- Clock and reset: single clock; reset is synchronous and active-low.
- Address decode: off = t_adr - BASE_ADDR; index = off >> log2(DATA_WIDTH/8).
  - Error if t_adr < BASE_ADDR, if index >= DEPTH, or if the low log2(DATA_WIDTH/8) address bits are not zero.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: at an edge with t_cyc & t_stb & !t_ack & !t_err, latch adr, dat_w, we, sel and the error flag.
    - If WAIT_STATES==0, go to RESP.
    - Otherwise load the counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement the counter each edge. When the counter is 0, go to RESP.
  - WAIT abort: t_cyc==0 at any WAIT edge returns to IDLE. No write is committed and no ack or err is issued.
  - RESP: t_ack (or t_err if the latched error flag is set) is high for exactly one cycle. Next edge returns to IDLE.
- Latency: the request is sampled at edge k; ack/err is high in the cycle after edge k+WAIT_STATES. With WAIT_STATES=0, ack follows the sampling edge by one cycle.
- t_ack and t_err are registered and never both high.
- A new request is not accepted in the ack cycle. Back-to-back throughput is one transfer per WAIT_STATES+2 cycles.
- Write: committed at the edge entering RESP, so the ack cycle already reflects the write.
  - For each lane i with sel[i]=1, mem[index] byte i = dat_w byte i; lanes with sel[i]=0 are unchanged.
  - sel==0 is acked with no change.
  - Errored writes never modify memory.
- Read: t_dat_r is loaded with mem[index] at the edge entering RESP. sel is ignored for reads.
  - Errored reads load t_dat_r with 0.
  - t_dat_r holds its value until the next read response.
- t_stb dropping while in WAIT does not abort; only t_cyc does.
- busy = (state != IDLE).
- Reset mid-transfer: return to IDLE next edge with outputs at reset values. A pending write is discarded.

Test Plan:
- WAIT_STATES=0: write 0xA5A50000@0x0, 0x5A5A1111@0x4, 0xDEADBEEF@0x8, then read the three addresses.
  - Each ack is exactly 1 cycle, 1 cycle after sampling.
  - Reads return the written values; t_err=0 throughout.
- Byte lanes: write 0xFFFFFFFF@0x10 sel=0xF, then write 0x00000012 sel=0x1, then write 0x00340000 sel=0x4.
  - Read @0x10 returns 0xFF34FF12.
- Errors with BASE_ADDR=0x1000, DEPTH=256:
  - Access 0x0FFC -> t_err one cycle, no ack.
  - Access 0x1400 -> t_err.
  - Access 0x1002 -> t_err.
  - Write 0x12345678@0x1400, then read 0x13FC -> prior contents unchanged.
- WAIT_STATES=3: request sampled at edge k -> ack high in the cycle after edge k+3.
  - busy is high for 4 cycles.
  - Back-to-back requests complete every 5 cycles.
- Abort with WAIT_STATES=5: write 0xCAFEF00D@0x20, drop t_cyc after 2 cycles.
  - No ack/err is issued and state returns to IDLE.
  - Read @0x20 returns the old value.
- Reset mid-WAIT: with WAIT_STATES=4, assert reset=0 for 1 cycle during WAIT.
  - Outputs are 0 on the next cycle and no ack is issued.
  - The write is not committed; a subsequent transfer completes normally.

Source files
------------

// File: rtl/fwvip_wb_target_mem_if.sv
// Wishbone bus bundle between an initiator (master) and fwvip_wb_target_mem (slave).
interface fwvip_wb_target_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   t_adr;
  logic [DATA_WIDTH-1:0]   t_dat_w;
  logic [DATA_WIDTH-1:0]   t_dat_r;
  logic                    t_cyc;
  logic                    t_stb;
  logic                    t_we;
  logic [DATA_WIDTH/8-1:0] t_sel;
  logic                    t_ack;
  logic                    t_err;

  modport master (
    output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
    input  t_dat_r, t_ack, t_err
  );

  modport slave (
    input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
    output t_dat_r, t_ack, t_err
  );
endinterface

// File: rtl/fwvip_wb_target_mem.sv
// Wishbone target backed by a word-addressed memory with programmable wait
// states, byte-lane writes and error termination for bad addresses.
module fwvip_wb_target_mem #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  fwvip_wb_target_mem_if.slave  bus,
  output logic                  busy
);
  localparam int unsigned LANES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((64'd1 << LANE_BITS) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] dat;
    logic [LANES-1:0]      sel;
    logic                  we;
    logic                  err;
  } req_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, dec_c, rsp_c;
  logic                  accept_c, commit_c;
  logic                  ack_q, err_q;
  logic [DATA_WIDTH-1:0] dat_r_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] off_c;
  logic                  below_c;

  // Address decode; the subtraction borrow flags addresses under the window.
  always_comb begin
    {below_c, off_c} = {1'b0, bus.t_adr} - {1'b0, BASE_ADDR};
    dec_c.idx = IDX_W'(off_c >> LANE_BITS);
    dec_c.dat = bus.t_dat_w;
    dec_c.sel = bus.t_sel;
    dec_c.we  = bus.t_we;
    dec_c.err = below_c || ((off_c >> LANE_BITS) >= DEPTH_A) || ((bus.t_adr & LANE_MASK) != '0);
  end

  // With zero wait states the response is formed from the live request.
  assign rsp_c = (state_q == S_IDLE) ? dec_c : req_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.t_cyc && bus.t_stb && !bus.t_ack && !bus.t_err) begin
          accept_c = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.t_cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = S_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != S_IDLE);
      ack_q   <= commit_c && !rsp_c.err;
      err_q   <= commit_c && rsp_c.err;
      if (accept_c) req_q <= dec_c;
      if (commit_c && !rsp_c.we) dat_r_q <= rsp_c.err ? '0 : mem[rsp_c.idx];
    end
  end

  // Memory is not reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (reset && commit_c && rsp_c.we && !rsp_c.err) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (rsp_c.sel[i]) mem[rsp_c.idx][i*8 +: 8] <= rsp_c.dat[i*8 +: 8];
      end
    end
  end

  assign bus.t_ack   = ack_q;
  assign bus.t_err   = err_q;
  assign bus.t_dat_r = dat_r_q;
endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Self-checking bench: five targets with different wait states / windows share
// one request driver; a word-array model predicts every response.
module tb_fwvip_wb_target_mem;
  localparam int N = 5;

  logic        clock;
  logic        reset;
  int          cur;
  logic [31:0] adr, dat_w;
  logic        cyc, stb, we;
  logic [3:0]  sel;

  logic [N-1:0] ack_v, err_v, busy_v;
  logic [31:0]  rd_a [N];

  int npass, ntotal;

  logic [31:0] mdl     [N][256];
  logic [31:0] last_rd [N];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fwvip_wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();
    assign ifc.t_adr   = adr;
    assign ifc.t_dat_w = dat_w;
    assign ifc.t_we    = we;
    assign ifc.t_sel   = sel;
    assign ifc.t_cyc   = cyc && (cur == g);
    assign ifc.t_stb   = stb && (cur == g);
    fwvip_wb_target_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (256),
      .BASE_ADDR  ((g == 1) ? 32'h1000 : 32'h0),
      .WAIT_STATES((g == 2) ? 3 : (g == 3) ? 5 : (g == 4) ? 4 : 0)
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (ifc.slave),
      .busy (busy_v[g])
    );
    assign ack_v[g] = ifc.t_ack;
    assign err_v[g] = ifc.t_err;
    assign rd_a[g]  = ifc.t_dat_r;
  end

  function automatic int ws_m(int k);
    return (k == 2) ? 3 : (k == 3) ? 5 : (k == 4) ? 4 : 0;
  endfunction

  function automatic logic [31:0] base_m(int k);
    return (k == 1) ? 32'h1000 : 32'h0;
  endfunction

  function automatic logic err_m(int k, logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_m(k));
    return (off < 0) || ((off / 4) >= 256) || (a[1:0] != 2'b00);
  endfunction

  function automatic int idx_m(int k, logic [31:0] a);
    return int'((longint'(a) - longint'(base_m(k))) / 4);
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s %s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
  endtask

  // Drive one request, wait for its termination, then release the bus.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic ga,
                      output logic ge, output int lat, output int bcnt, output logic tail);
    @(negedge clock);
    cur = k; adr = a; dat_w = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clock);
    lat = -1; bcnt = 0; ga = 1'b0; ge = 1'b0; rd = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (busy_v[k]) bcnt++;
      if (ack_v[k] || err_v[k]) begin
        lat = n; ga = ack_v[k]; ge = err_v[k]; rd = rd_a[k];
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clock);
    tail = ack_v[k] | err_v[k] | busy_v[k];
  endtask

  // One transfer checked against the model; the model is updated afterwards.
  task automatic run(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    logic ga, ge, tail, e;
    int lat, bcnt, i;
    logic [31:0] exp;
    string t;
    t = $sformatf("k%0d %s@%08h", k, w ? "wr" : "rd", a);
    xfer(k, w, a, d, s, rd, ga, ge, lat, bcnt, tail);
    e = err_m(k, a);
    chk(t, "latency", 32'(lat), 32'(ws_m(k)));
    chk(t, "ack", 32'(ga), 32'(!e));
    chk(t, "err", 32'(ge), 32'(e));
    chk(t, "busy_cycles", 32'(bcnt), 32'(ws_m(k) + 1));
    chk(t, "one_cycle_resp", 32'(tail), 32'd0);
    if (w) begin
      chk(t, "dat_r_held", rd, last_rd[k]);
      if (!e) begin
        i = idx_m(k, a);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[k][i][b*8 +: 8] = d[b*8 +: 8];
      end
    end else begin
      exp = e ? 32'h0 : mdl[k][idx_m(k, a)];
      chk(t, "rdata", rd, exp);
      last_rd[k] = exp;
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    logic seen;
    int acks[$];
    int r, k;

    npass = 0; ntotal = 0;
    reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0; cur = 0;
    for (int j = 0; j < N; j++) last_rd[j] = '0;

    repeat (3) @(negedge clock);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("reset k%0d", j), "ack", 32'(ack_v[j]), 32'd0);
      chk($sformatf("reset k%0d", j), "err", 32'(err_v[j]), 32'd0);
      chk($sformatf("reset k%0d", j), "busy", 32'(busy_v[j]), 32'd0);
      chk($sformatf("reset k%0d", j), "dat_r", rd_a[j], 32'd0);
    end
    reset = 1'b1;

    // Give every word the later steps can touch a known value.
    for (int j = 0; j < N; j++)
      for (int w = 0; w < 16; w++) run(j, 1'b1, base_m(j) + 32'(w * 4), $urandom, 4'hF, rd);

    run(0, 1'b1, 32'h0, 32'hA5A50000, 4'hF, rd);
    run(0, 1'b1, 32'h4, 32'h5A5A1111, 4'hF, rd);
    run(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd);
    run(0, 1'b0, 32'h0, 32'h0, 4'hF, rd); chk("ws0 rd 0x0", "literal", rd, 32'hA5A50000);
    run(0, 1'b0, 32'h4, 32'h0, 4'hF, rd); chk("ws0 rd 0x4", "literal", rd, 32'h5A5A1111);
    run(0, 1'b0, 32'h8, 32'h0, 4'hF, rd); chk("ws0 rd 0x8", "literal", rd, 32'hDEADBEEF);

    run(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, rd);
    run(0, 1'b1, 32'h10, 32'h00000012, 4'h1, rd);
    run(0, 1'b1, 32'h10, 32'h00340000, 4'h4, rd);
    run(0, 1'b1, 32'h10, 32'h77777777, 4'h0, rd);
    run(0, 1'b0, 32'h10, 32'h0, 4'h0, rd); chk("lanes rd 0x10", "literal", rd, 32'hFF34FF12);

    run(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, rd); chk("err below", "rdata_zero", rd, 32'h0);
    run(1, 1'b1, 32'h1400, 32'h0, 4'hF, rd);
    run(1, 1'b0, 32'h1002, 32'h0, 4'hF, rd);
    run(1, 1'b1, 32'h13FC, 32'h0BADF00D, 4'hF, rd);
    run(1, 1'b1, 32'h1400, 32'h12345678, 4'hF, rd);
    run(1, 1'b0, 32'h13FC, 32'h0, 4'hF, rd); chk("err no write", "literal", rd, 32'h0BADF00D);

    run(2, 1'b0, 32'h0, 32'h0, 4'hF, rd);

    // Back-to-back: hold the request and time the ack pulses.
    @(negedge clock);
    cur = 2; adr = 32'h4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (ack_v[2]) acks.push_back(n);
      if (acks.size() >= 3) break;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clock);
    chk("b2b", "ack_count", 32'(acks.size()), 32'd3);
    if (acks.size() >= 3) begin
      chk("b2b", "period1", 32'(acks[1] - acks[0]), 32'd5);
      chk("b2b", "period2", 32'(acks[2] - acks[1]), 32'd5);
    end
    chk("b2b", "rdata", rd_a[2], mdl[2][1]);
    last_rd[2] = mdl[2][1];

    run(3, 1'b1, 32'h20, 32'h11111111, 4'hF, rd);
    @(negedge clock);
    cur = 3; adr = 32'h20; dat_w = 32'hCAFEF00D; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clock);
    repeat (2) @(negedge clock);
    cyc = 1'b0; stb = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | ack_v[3] | err_v[3];
    end
    chk("abort", "resp_seen", 32'(seen), 32'd0);
    chk("abort", "busy", 32'(busy_v[3]), 32'd0);
    run(3, 1'b0, 32'h20, 32'h0, 4'hF, rd); chk("abort rd 0x20", "literal", rd, 32'h11111111);

    run(4, 1'b1, 32'h30, 32'h22222222, 4'hF, rd);
    @(negedge clock);
    cur = 4; adr = 32'h30; dat_w = 32'h33333333; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset", "ack", 32'(ack_v[4]), 32'd0);
    chk("midreset", "err", 32'(err_v[4]), 32'd0);
    chk("midreset", "busy", 32'(busy_v[4]), 32'd0);
    chk("midreset", "dat_r", rd_a[4], 32'd0);
    reset = 1'b1; cyc = 1'b0; stb = 1'b0;
    for (int j = 0; j < N; j++) last_rd[j] = '0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | ack_v[4] | err_v[4];
    end
    chk("midreset", "resp_seen", 32'(seen), 32'd0);
    run(4, 1'b0, 32'h30, 32'h0, 4'hF, rd); chk("midreset rd 0x30", "literal", rd, 32'h22222222);
    run(4, 1'b1, 32'h34, 32'h44444444, 4'hF, rd);
    run(4, 1'b0, 32'h34, 32'h0, 4'hF, rd);

    // Random mix across the zero/three/five-wait and offset-window targets.
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 7)       a = base_m(k) + 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = base_m(k) + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = base_m(k) + 32'h400 + 32'($urandom_range(0, 15) * 4);
      else             a = (base_m(k) == 0) ? 32'h800 : base_m(k) - 32'h4;
      run(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
